// File: rtl/ann_job_arbiter_if.sv
// Bundle of requester, core and response signals around the ANN job arbiter.
// master = arbiter side, slave = host/core environment side.
interface ann_job_arbiter_if #(
  parameter int N_REQ  = 4,
  parameter int ID_W   = 2,
  parameter int DATA_W = 32
);
  logic [N_REQ-1:0]  req;
  logic              core_start;
  logic              core_done;
  logic [DATA_W-1:0] core_result;
  logic              core_rst_n;
  logic              busy;
  // Response handshake: a beat transfers on a rising edge where rsp_valid && rsp_ready.
  // rsp_valid never depends on rsp_ready; once raised, rsp_id/rsp_data/rsp_err hold
  // until that transfer, and rsp_ready may be high before rsp_valid appears.
  logic              rsp_valid;
  logic              rsp_ready;
  logic [ID_W-1:0]   rsp_id;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_err;
  logic [2:0]        dbg_state;

  modport master (
    input  req, core_done, core_result, rsp_ready,
    output core_start, core_rst_n, busy, rsp_valid, rsp_id, rsp_data, rsp_err, dbg_state
  );

  modport slave (
    output req, core_done, core_result, rsp_ready,
    input  core_start, core_rst_n, busy, rsp_valid, rsp_id, rsp_data, rsp_err, dbg_state
  );
endinterface

// File: rtl/ann_job_arbiter.sv
// Round-robin sharing of one start/done inference core among N_REQ requesters,
// with timeout abort, local core reset and a registered valid/ready response port.
module ann_job_arbiter #(
  parameter int N_REQ          = 4,
  parameter int ID_W           = 2,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 2500,
  parameter int RECOVER_CYCLES = 2
) (
  input  logic               clock,
  input  logic               reset,
  ann_job_arbiter_if.master  bus
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_START   = 3'd1;
  localparam logic [2:0] S_BUSY    = 3'd2;
  localparam logic [2:0] S_DELIVER = 3'd3;
  localparam logic [2:0] S_RECOVER = 3'd4;

  localparam int CNT_MAX = (TIMEOUT_CYCLES > RECOVER_CYCLES) ? TIMEOUT_CYCLES : RECOVER_CYCLES;
  localparam int TMR_W   = $clog2(CNT_MAX + 1);
  localparam logic [TMR_W-1:0] TMO_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TMR_W-1:0] REC_LAST = TMR_W'(RECOVER_CYCLES - 1);
  localparam logic [ID_W-1:0]  ID_LAST  = ID_W'(N_REQ - 1);

  logic [2:0]        state_q,      state_d;
  logic [ID_W-1:0]   rr_ptr_q,     rr_ptr_d;
  logic [N_REQ-1:0]  mask_q,       mask_d;
  logic [TMR_W-1:0]  timer_q,      timer_d;
  logic              core_start_q, core_start_d;
  logic              core_rst_n_q, core_rst_n_d;
  logic              busy_q,       busy_d;
  logic              rsp_valid_q,  rsp_valid_d;
  logic [ID_W-1:0]   rsp_id_q,     rsp_id_d;
  logic [DATA_W-1:0] rsp_data_q,   rsp_data_d;
  logic              rsp_err_q,    rsp_err_d;

  logic [N_REQ-1:0]  eligible;
  logic              grant_found;
  logic [ID_W-1:0]   grant_id;
  logic [31:0]       cand;

  // Search starts at rr_ptr and wraps; the requester just served is masked for one IDLE cycle.
  always_comb begin
    eligible    = bus.req & ~mask_q;
    grant_found = 1'b0;
    grant_id    = '0;
    cand        = '0;
    for (int i = 0; i < N_REQ; i++) begin
      cand = 32'(rr_ptr_q) + 32'(i);
      if (cand >= 32'(N_REQ)) cand = cand - 32'(N_REQ);
      if (!grant_found && eligible[cand[ID_W-1:0]]) begin
        grant_found = 1'b1;
        grant_id    = cand[ID_W-1:0];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    mask_d       = mask_q;
    timer_d      = timer_q;
    core_start_d = 1'b0;
    core_rst_n_d = core_rst_n_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_data_d   = rsp_data_q;
    rsp_err_d    = rsp_err_q;

    case (state_q)
      S_IDLE: begin
        mask_d = '0;
        if (grant_found) begin
          rsp_id_d     = grant_id;
          rr_ptr_d     = (grant_id == ID_LAST) ? '0 : grant_id + ID_W'(1);
          core_start_d = 1'b1;
          state_d      = S_START;
        end
      end
      S_START: begin
        timer_d = '0;
        state_d = S_BUSY;
      end
      S_BUSY: begin
        timer_d = timer_q + TMR_W'(1);
        // A done arriving on the expiry cycle still counts as a good result.
        if (bus.core_done) begin
          rsp_data_d  = bus.core_result;
          rsp_err_d   = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = S_DELIVER;
        end else if (timer_q == TMO_LAST) begin
          rsp_data_d   = '0;
          rsp_err_d    = 1'b1;
          core_rst_n_d = 1'b0;
          timer_d      = '0;
          state_d      = S_RECOVER;
        end
      end
      S_RECOVER: begin
        if (timer_q == REC_LAST) begin
          core_rst_n_d = 1'b1;
          rsp_valid_d  = 1'b1;
          state_d      = S_DELIVER;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      S_DELIVER: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          mask_d      = N_REQ'(1) << rsp_id_q;
          state_d     = S_IDLE;
        end
      end
      default: begin
        state_d      = S_IDLE;
        core_rst_n_d = 1'b1;
        rsp_valid_d  = 1'b0;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      rr_ptr_q     <= '0;
      mask_q       <= '0;
      timer_q      <= '0;
      core_start_q <= 1'b0;
      core_rst_n_q <= 1'b1;
      busy_q       <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= '0;
      rsp_data_q   <= '0;
      rsp_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      mask_q       <= mask_d;
      timer_q      <= timer_d;
      core_start_q <= core_start_d;
      core_rst_n_q <= core_rst_n_d;
      busy_q       <= busy_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_data_q   <= rsp_data_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

  assign bus.core_start = core_start_q;
  assign bus.core_rst_n = core_rst_n_q;
  assign bus.busy       = busy_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_id     = rsp_id_q;
  assign bus.rsp_data   = rsp_data_q;
  assign bus.rsp_err    = rsp_err_q;
  assign bus.dbg_state  = state_q;

endmodule

// File: tb/tb_ann_job_arbiter.sv
// Bench for ann_job_arbiter: job table, directed corner sequences and a randomized
// run scored against a job-level round-robin model.
module tb_ann_job_arbiter;
  localparam int N_REQ   = 4;
  localparam int ID_W    = 2;
  localparam int DATA_W  = 32;
  localparam int TMO     = 2500;
  localparam int REC     = 2;
  localparam int NV      = 10;

  logic clock;
  logic reset;
  int   n_cmp  = 0;
  int   n_fail = 0;

  ann_job_arbiter_if #(.N_REQ(N_REQ), .ID_W(ID_W), .DATA_W(DATA_W)) bus ();

  ann_job_arbiter #(
    .N_REQ(N_REQ), .ID_W(ID_W), .DATA_W(DATA_W),
    .TIMEOUT_CYCLES(TMO), .RECOVER_CYCLES(REC)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #(10 * 100000);
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard helpers ----------------
  typedef struct {
    logic [N_REQ-1:0] req;
    int               lat;      // 0 = core never answers
    logic [31:0]      res;
    logic [ID_W-1:0]  exp_id;
    logic [31:0]      exp_data;
    logic             exp_err;
  } vec_t;

  vec_t vecs[NV];
  logic [ID_W+DATA_W:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic wait_start(input string tag, output int n);
    bit seen;
    seen = 0;
    n    = 0;
    while (n < 40) begin
      @(negedge clock);
      n++;
      if (bus.core_start) begin
        seen = 1;
        break;
      end
    end
    check({tag, "_start_seen"}, 64'(seen), 64'd1);
  endtask

  task automatic job_body(input string tag, input int lat, input logic [31:0] res);
    bit extra_start;
    bit rst_low;
    int n;
    int lowc;
    extra_start = 0;
    rst_low     = 0;
    if (lat > 0) begin
      for (int c = 1; c <= lat; c++) begin
        @(negedge clock);
        if (bus.core_start) extra_start = 1;
        if (!bus.core_rst_n) rst_low = 1;
        if (c == lat) begin
          bus.core_done   = 1'b1;
          bus.core_result = res;
        end else begin
          bus.core_result = $urandom;
        end
      end
      @(negedge clock);
      bus.core_done = 1'b0;
      if (!bus.core_rst_n) rst_low = 1;
      check({tag, "_single_start"}, 64'(extra_start), 64'd0);
      check({tag, "_core_rst_n_high"}, 64'(rst_low), 64'd0);
      check({tag, "_done_to_valid"}, 64'(bus.rsp_valid), 64'd1);
    end else begin
      n = 0;
      while (n < TMO + 20) begin
        @(negedge clock);
        n++;
        if (bus.core_start) extra_start = 1;
        if (!bus.core_rst_n) break;
      end
      check({tag, "_rst_fall_cycle"}, 64'(n), 64'(TMO + 1));
      lowc = 1;
      while (lowc < 20) begin
        @(negedge clock);
        if (bus.core_rst_n) break;
        lowc++;
      end
      check({tag, "_rst_low_cycles"}, 64'(lowc), 64'(REC));
      check({tag, "_single_start"}, 64'(extra_start), 64'd0);
      check({tag, "_valid_after_recover"}, 64'(bus.rsp_valid), 64'd1);
    end
  endtask

  task automatic accept(input string tag);
    bus.rsp_ready = 1'b1;
    @(negedge clock);
    bus.rsp_ready = 1'b0;
    check({tag, "_valid_drop"}, 64'(bus.rsp_valid), 64'd0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_core_start"}, 64'(bus.core_start), 64'd0);
    check({tag, "_core_rst_n"}, 64'(bus.core_rst_n), 64'd1);
    check({tag, "_busy"},       64'(bus.busy),       64'd0);
    check({tag, "_rsp_valid"},  64'(bus.rsp_valid),  64'd0);
    check({tag, "_rsp_id"},     64'(bus.rsp_id),     64'd0);
    check({tag, "_rsp_data"},   64'(bus.rsp_data),   64'd0);
    check({tag, "_rsp_err"},    64'(bus.rsp_err),    64'd0);
    check({tag, "_state"},      64'(bus.dbg_state),  64'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int n;
    int ptr;
    int cur_id;
    int lat_left;
    int n_done;
    bit job_active;
    bit found;
    bit rv;
    bit rdy;
    bit bad_valid;
    bit bad_stable;
    bit bad_start;
    bit bad_rsp;
    logic [31:0] cur_res;
    logic [N_REQ-1:0] req_r;
    logic [N_REQ-1:0] g;
    logic [ID_W+DATA_W:0] e;
    logic [ID_W-1:0] s_id;
    logic [31:0] s_data;
    logic s_err;
    int wait_cnt[N_REQ];

    vecs[0] = '{4'b0001, 40,   32'd7,          2'd0, 32'd7,          1'b0};
    vecs[1] = '{4'b1000, 3,    32'd11,         2'd3, 32'd11,         1'b0};
    vecs[2] = '{4'b1111, 5,    32'd100,        2'd0, 32'd100,        1'b0};
    vecs[3] = '{4'b1111, 5,    32'd101,        2'd1, 32'd101,        1'b0};
    vecs[4] = '{4'b1111, 5,    32'd102,        2'd2, 32'd102,        1'b0};
    vecs[5] = '{4'b1111, 5,    32'd103,        2'd3, 32'd103,        1'b0};
    vecs[6] = '{4'b1111, 5,    32'd104,        2'd0, 32'd104,        1'b0};
    vecs[7] = '{4'b0100, TMO,  32'd3,          2'd2, 32'd3,          1'b0};
    vecs[8] = '{4'b0100, 0,    32'd0,          2'd2, 32'd0,          1'b1};
    vecs[9] = '{4'b0010, 8,    32'hDEADBEEF,   2'd1, 32'hDEADBEEF,   1'b0};

    reset           = 1'b0;
    bus.req         = '0;
    bus.core_done   = 1'b0;
    bus.core_result = '0;
    bus.rsp_ready   = 1'b0;
    repeat (3) @(negedge clock);
    check_reset_values("reset");
    reset = 1'b1;

    // Job table: single job, round-robin order, exact-timeout done, timeout, recovery.
    for (int i = 0; i < NV; i++) begin
      bus.req = vecs[i].req;
      wait_start($sformatf("v%0d", i), n);
      job_body($sformatf("v%0d", i), vecs[i].lat, vecs[i].res);
      check($sformatf("v%0d_rsp_id", i),   64'(bus.rsp_id),   64'(vecs[i].exp_id));
      check($sformatf("v%0d_rsp_data", i), 64'(bus.rsp_data), 64'(vecs[i].exp_data));
      check($sformatf("v%0d_rsp_err", i),  64'(bus.rsp_err),  64'(vecs[i].exp_err));
      check($sformatf("v%0d_busy", i),     64'(bus.busy),     64'd1);
      accept($sformatf("v%0d", i));
    end

    // Backpressure: response held stable, no new start while unaccepted.
    bus.req = 4'b0001;
    wait_start("bp", n);
    job_body("bp", 5, 32'h55);
    bus.req = 4'b1111;
    s_id = bus.rsp_id;
    s_data = bus.rsp_data;
    s_err = bus.rsp_err;
    bad_valid = 0;
    bad_stable = 0;
    bad_start = 0;
    repeat (10) begin
      @(negedge clock);
      if (!bus.rsp_valid) bad_valid = 1;
      if (bus.rsp_id !== s_id || bus.rsp_data !== s_data || bus.rsp_err !== s_err) bad_stable = 1;
      if (bus.core_start) bad_start = 1;
    end
    check("bp_rsp_id", 64'(s_id), 64'd0);
    check("bp_rsp_data", 64'(s_data), 64'h55);
    check("bp_valid_held", 64'(bad_valid), 64'd0);
    check("bp_outputs_stable", 64'(bad_stable), 64'd0);
    check("bp_no_start", 64'(bad_start), 64'd0);
    bus.req = 4'b0000;
    accept("bp");

    // Just-served requester that keeps req high sits out one IDLE cycle.
    bus.req = 4'b0001;
    wait_start("mask_a", n);
    job_body("mask_a", 3, 32'd5);
    accept("mask_a");
    wait_start("mask_b", n);
    check("mask_start_gap", 64'(n), 64'd2);
    job_body("mask_b", 3, 32'd9);
    check("mask_rsp_id", 64'(bus.rsp_id), 64'd0);
    check("mask_rsp_data", 64'(bus.rsp_data), 64'd9);
    bus.req = 4'b0000;
    accept("mask_b");

    // Stray core_done while idle must be ignored.
    bus.core_done = 1'b1;
    bus.core_result = 32'hBAD;
    @(negedge clock);
    bus.core_done = 1'b0;
    bad_rsp = 0;
    repeat (5) begin
      @(negedge clock);
      if (bus.rsp_valid || bus.busy || bus.core_start) bad_rsp = 1;
    end
    check("stray_no_response", 64'(bad_rsp), 64'd0);
    check("stray_data_unchanged", 64'(bus.rsp_data), 64'd9);

    // Async reset mid-job, then a held req restarts from pointer 0.
    bus.req = 4'b0010;
    wait_start("ares", n);
    repeat (3) @(negedge clock);
    #2 reset = 1'b0;
    #1 check_reset_values("ares");
    @(negedge clock);
    bus.req = 4'b1111;
    reset = 1'b1;
    wait_start("ares_after", n);
    check("ares_restart_id", 64'(bus.rsp_id), 64'd0);
    job_body("ares_after", 4, 32'h1234);
    check("ares_rsp_data", 64'(bus.rsp_data), 64'h1234);
    bus.req = 4'b0000;
    accept("ares_after");

    // Randomized traffic against the job-level round-robin model.
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    ptr = 0;
    req_r = '0;
    job_active = 0;
    lat_left = 0;
    cur_id = 0;
    cur_res = '0;
    n_done = 0;
    for (int i = 0; i < N_REQ; i++) wait_cnt[i] = $urandom_range(0, 3);
    for (int cyc = 0; cyc < 2800; cyc++) begin
      @(negedge clock);
      if (bus.core_start) begin
        g = bus.req;
        found = 0;
        for (int i = 0; i < N_REQ; i++) begin
          if (!found && g[(ptr + i) % N_REQ]) begin
            found = 1;
            cur_id = (ptr + i) % N_REQ;
          end
        end
        if (job_active || !found) check("rnd_unexpected_start", 64'd1, 64'd0);
        ptr = (cur_id + 1) % N_REQ;
        job_active = 1;
        lat_left = $urandom_range(2, 12);
        cur_res = $urandom;
      end
      rv = bus.rsp_valid;

      if (job_active) begin
        lat_left--;
        if (lat_left == 0) begin
          bus.core_done = 1'b1;
          bus.core_result = cur_res;
          exp_q.push_back({ID_W'(cur_id), cur_res, 1'b0});
          job_active = 0;
        end else begin
          bus.core_done = 1'b0;
          bus.core_result = $urandom;
        end
      end else begin
        bus.core_done = ($urandom_range(0, 7) == 0);
        bus.core_result = $urandom;
      end

      for (int i = 0; i < N_REQ; i++) begin
        if (!req_r[i] && cyc < 2500) begin
          if (wait_cnt[i] == 0) req_r[i] = 1'b1;
          else wait_cnt[i]--;
        end
      end

      rdy = ($urandom_range(0, 3) != 0);
      bus.rsp_ready = rdy;
      if (rv && rdy) begin
        if (exp_q.size() == 0) begin
          check("rnd_unexpected_rsp", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("rnd_rsp_id",   64'(bus.rsp_id),   64'(e[DATA_W+ID_W:DATA_W+1]));
          check("rnd_rsp_data", 64'(bus.rsp_data), 64'(e[DATA_W:1]));
          check("rnd_rsp_err",  64'(bus.rsp_err),  64'(e[0]));
          req_r[e[DATA_W+ID_W:DATA_W+1]] = 1'b0;
          wait_cnt[e[DATA_W+ID_W:DATA_W+1]] = $urandom_range(2, 8);
          n_done++;
        end
      end
      bus.req = req_r;
    end
    bus.rsp_ready = 1'b0;
    bus.core_done = 1'b0;
    @(negedge clock);
    check("rnd_queue_drained", 64'(exp_q.size()), 64'd0);
    check("rnd_idle_at_end", 64'(bus.busy), 64'd0);
    check("rnd_enough_jobs", 64'(n_done >= 30), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
